// File: rtl/aq_mmu_tlb_sram_ctrl.sv
// Single-port TLB SRAM access controller: arbitrates invalidate-all sweep,
// refill writes and lookup reads onto one 64x88 bank with active-low controls.
module aq_mmu_tlb_sram_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 88,
  parameter int DEPTH      = 64,
  parameter int VLD_BIT    = 87
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  lkp_req,
  input  logic [ADDR_WIDTH-1:0] lkp_idx,
  output logic                  lkp_gnt,
  output logic                  lkp_rd_vld,
  output logic [DATA_WIDTH-1:0] lkp_rd_data,
  input  logic                  rfl_req,
  input  logic [ADDR_WIDTH-1:0] rfl_idx,
  input  logic [DATA_WIDTH-1:0] rfl_data,
  output logic                  rfl_gnt,
  input  logic                  inv_req,
  output logic                  inv_busy,
  output logic                  inv_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  // Sweep writes touch only the valid flag; every other bit is masked off.
  localparam logic [DATA_WIDTH-1:0] VLD_MASK = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << VLD_BIT;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_inv_cnt;
  logic                    r_lkp_rd_vld;
  logic                    r_inv_done;
  logic                    w_cnt_last;

  assign w_cnt_last = (r_inv_cnt == LAST_IDX);

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (inv_req)    w_state_nxt = ST_SWEEP;
      ST_SWEEP: if (w_cnt_last) w_state_nxt = ST_IDLE;
      default:                  w_state_nxt = ST_IDLE;
    endcase
  end

  // Grants and SRAM controls are combinational so a granted access hits the
  // SRAM in the same cycle; the inv_req cycle deliberately grants nothing.
  always_comb begin
    lkp_gnt   = 1'b0;
    rfl_gnt   = 1'b0;
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    case (r_state)
      ST_SWEEP: begin
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = ~VLD_MASK;
        sram_a    = r_inv_cnt;
      end
      default: begin
        if (!inv_req) begin
          if (rfl_req) begin
            rfl_gnt   = 1'b1;
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = rfl_idx;
            sram_d    = rfl_data;
          end else if (lkp_req) begin
            lkp_gnt   = 1'b1;
            sram_cen  = 1'b0;
            sram_a    = lkp_idx;
          end
        end
      end
    endcase
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_inv_cnt    <= '0;
      r_lkp_rd_vld <= 1'b0;
      r_inv_done   <= 1'b0;
    end else begin
      r_inv_cnt    <= (r_state == ST_SWEEP) ? r_inv_cnt + 1'b1 : '0;
      r_lkp_rd_vld <= lkp_gnt;
      r_inv_done   <= (r_state == ST_SWEEP) && w_cnt_last;
    end
  end

  assign inv_busy    = (r_state == ST_SWEEP);
  assign inv_done    = r_inv_done;
  assign lkp_rd_vld  = r_lkp_rd_vld;
  assign lkp_rd_data = sram_q;

endmodule

// File: tb/tb_aq_mmu_tlb_sram_ctrl.sv
// Bench for aq_mmu_tlb_sram_ctrl: behavioural SRAM plus a per-cycle reference
// model of arbitration, sweep timing and expected entry contents.
module tb_aq_mmu_tlb_sram_ctrl;

  localparam int AW  = 6;
  localparam int DW  = 88;
  localparam int DEP = 64;
  localparam int VB  = 87;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lkp_req = 1'b0;
  logic [AW-1:0] lkp_idx = '0;
  logic          lkp_gnt;
  logic          lkp_rd_vld;
  logic [DW-1:0] lkp_rd_data;
  logic          rfl_req = 1'b0;
  logic [AW-1:0] rfl_idx = '0;
  logic [DW-1:0] rfl_data = '0;
  logic          rfl_gnt;
  logic          inv_req = 1'b0;
  logic          inv_busy;
  logic          inv_done;
  logic [AW-1:0] sram_a;
  logic          sram_cen;
  logic          sram_gwen;
  logic [DW-1:0] sram_wen;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q = '0;

  always #5 clk = ~clk;

  aq_mmu_tlb_sram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP), .VLD_BIT(VB)) dut (
    .forever_cpuclk(clk), .cpurst_b(rst_n),
    .lkp_req(lkp_req), .lkp_idx(lkp_idx), .lkp_gnt(lkp_gnt),
    .lkp_rd_vld(lkp_rd_vld), .lkp_rd_data(lkp_rd_data),
    .rfl_req(rfl_req), .rfl_idx(rfl_idx), .rfl_data(rfl_data), .rfl_gnt(rfl_gnt),
    .inv_req(inv_req), .inv_busy(inv_busy), .inv_done(inv_done),
    .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen),
    .sram_wen(sram_wen), .sram_d(sram_d), .sram_q(sram_q)
  );

  // Behavioural single-port SRAM with per-bit write enables and registered read.
  logic [DW-1:0] sram_mem [DEP];
  initial for (int i = 0; i < DEP; i++) sram_mem[i] = '0;
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= sram_mem[sram_a];
    end
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [DEP];
  int            m_sweep_left = 0;
  bit            m_pend_rd = 1'b0;
  int            m_pend_idx = 0;
  bit            m_done_next = 1'b0;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: check every DUT output against the model mid-cycle, then
  // advance the model by the accesses the spec says happen this cycle.
  task automatic step(output bit g_lkp, output bit g_rfl);
    logic [DW-1:0] e_wen, e_d;
    logic [AW-1:0] e_a;
    bit            e_cen, e_gwen, e_busy, e_lg, e_rg;
    @(negedge clk);
    e_cen = 1; e_gwen = 1; e_wen = '1; e_d = '0; e_a = '0;
    e_busy = 0; e_lg = 0; e_rg = 0;
    if (m_sweep_left > 0) begin
      e_busy = 1; e_cen = 0; e_gwen = 0; e_d = '0;
      e_a = AW'(DEP - m_sweep_left);
      e_wen = '1; e_wen[VB] = 1'b0;
    end else if (inv_req) begin
      e_busy = 0;
    end else if (rfl_req) begin
      e_rg = 1; e_cen = 0; e_gwen = 0; e_wen = '0; e_a = rfl_idx; e_d = rfl_data;
    end else if (lkp_req) begin
      e_lg = 1; e_cen = 0; e_gwen = 1; e_a = lkp_idx;
    end
    chk("sram_cen", sram_cen, e_cen);
    chk("sram_gwen", sram_gwen, e_gwen);
    chk("sram_a", sram_a, e_a);
    if (!e_lg) begin
      chk("sram_wen", sram_wen, e_wen);
      chk("sram_d", sram_d, e_d);
    end
    chk("lkp_gnt", lkp_gnt, e_lg);
    chk("rfl_gnt", rfl_gnt, e_rg);
    chk("inv_busy", inv_busy, e_busy);
    chk("inv_done", inv_done, m_done_next);
    chk("lkp_rd_vld", lkp_rd_vld, m_pend_rd);
    if (m_pend_rd) chk($sformatf("rd_data[%0d]", m_pend_idx), lkp_rd_data, ref_mem[m_pend_idx]);
    if (e_rg) ref_mem[rfl_idx] = rfl_data;
    if (e_busy) ref_mem[e_a][VB] = 1'b0;
    m_done_next = (m_sweep_left == 1);
    m_pend_rd   = e_lg;
    m_pend_idx  = int'(lkp_idx);
    if (m_sweep_left > 0) m_sweep_left--;
    else if (inv_req) m_sweep_left = DEP;
    g_lkp = e_lg;
    g_rfl = e_rg;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int cycles);
    bit gl, gr;
    rst_n = 1'b0;
    lkp_req = 0; rfl_req = 0; inv_req = 0;
    m_sweep_left = 0; m_pend_rd = 0; m_done_next = 0;
    for (int i = 0; i < cycles; i++) step(gl, gr);
    rst_n = 1'b1;
  endtask

  task automatic do_refill(input int idx, input logic [DW-1:0] data);
    bit gl, gr;
    int n;
    rfl_req = 1; rfl_idx = AW'(idx); rfl_data = data;
    n = 0;
    do begin step(gl, gr); n++; end while (!gr && n < 200);
    if (!gr) chk("rfl_timeout", 0, 1);
    rfl_req = 0;
  endtask

  task automatic do_lookup(input int idx);
    bit gl, gr;
    int n;
    lkp_req = 1; lkp_idx = AW'(idx);
    n = 0;
    do begin step(gl, gr); n++; end while (!gl && n < 200);
    if (!gl) chk("lkp_timeout", 0, 1);
    lkp_req = 0;
    step(gl, gr);
  endtask

  initial begin
    bit gl, gr;
    logic [DW-1:0] pat;
    logic [DW-1:0] entry;
    for (int i = 0; i < DEP; i++) ref_mem[i] = '0;
    pat = {11{8'hA5}};

    do_reset(3);

    // Refill then lookup of the same index.
    do_refill(5, 88'h12_3456_789A_BCDE_F013_ABCD);
    do_lookup(5);

    // Simultaneous refill and lookup: refill wins, lookup follows.
    rfl_req = 1; rfl_idx = 6'd3; rfl_data = {$urandom, $urandom, $urandom} & {DW{1'b1}};
    lkp_req = 1; lkp_idx = 6'd9;
    step(gl, gr);
    chk("simul_first_is_rfl", {gl, gr}, 2'b01);
    rfl_req = 0;
    step(gl, gr);
    chk("simul_second_is_lkp", {gl, gr}, 2'b10);
    lkp_req = 0;
    step(gl, gr);
    do_lookup(3);

    // Full preload, invalidate-all, lookup stalled from sweep cycle 10.
    for (int i = 0; i < DEP; i++) begin
      entry = pat; entry[VB] = 1'b1; entry[7:0] = 8'(i);
      do_refill(i, entry);
    end
    inv_req = 1;
    step(gl, gr);
    inv_req = 0;
    for (int c = 0; c < DEP; c++) begin
      if (c == 10) begin lkp_req = 1; lkp_idx = 6'd7; end
      step(gl, gr);
    end
    step(gl, gr);
    chk("stall_grant_first_idle", gl, 1'b1);
    lkp_req = 0;
    step(gl, gr);
    for (int i = 0; i < DEP; i++) do_lookup(i);

    // Reset in the middle of a sweep, just before entry 20 is written.
    for (int i = 0; i < DEP; i++) begin
      entry = ~pat; entry[VB] = 1'b1; entry[15:8] = 8'(i);
      do_refill(i, entry);
    end
    inv_req = 1;
    step(gl, gr);
    inv_req = 0;
    for (int c = 0; c < 20; c++) step(gl, gr);
    do_reset(2);
    for (int c = 0; c < 70; c++) step(gl, gr);
    for (int i = 0; i < DEP; i++) begin
      do_lookup(i);
      chk($sformatf("vld_after_rst[%0d]", i), ref_mem[i][VB], (i >= 20));
    end

    // Randomised mix of all three requesters.
    for (int c = 0; c < 600; c++) begin
      inv_req  = ($urandom_range(0, 79) == 0);
      rfl_req  = $urandom_range(0, 2) == 0;
      lkp_req  = $urandom_range(0, 1) == 1;
      rfl_idx  = AW'($urandom);
      lkp_idx  = AW'($urandom);
      rfl_data = {$urandom, $urandom, $urandom} & {DW{1'b1}};
      step(gl, gr);
    end
    inv_req = 0; rfl_req = 0; lkp_req = 0;
    for (int c = 0; c < 70; c++) step(gl, gr);
    for (int i = 0; i < DEP; i++) do_lookup(i);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
